// File: rtl/i2c_slave_regs_pkg.sv
// Shared types and constants for the I2C register-target slave.
// States, ACK/NACK line levels, R/W encoding and the bit-counter width.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;
  localparam int   BIT_CNT_W   = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Bus pins and register-file port of the I2C register-target slave.
// slave = the target RTL, master = the environment driving pads and the register file.
interface i2c_slave_regs_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, busy
  );
endinterface

// File: rtl/i2c_slave_regs_line_sync.sv
// 2-FF synchronizer plus registered level/rise/fall for one bus line; 3 clk pad-to-pulse.
// I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter (rejects 1-clk pulses, 5 clk latency).
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_lvl;
  logic       r_rise;
  logic       r_fall;
  logic       w_filt;

  // Lines idle high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_line};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_maj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= 2'b11;
      r_maj  <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
      r_maj  <= maj3(r_sync[1], r_hist[0], r_hist[1]);
    end
  end

  assign w_filt = r_maj;
`else
  assign w_filt = r_sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lvl  <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_lvl  <= w_filt;
      r_rise <= w_filt & ~r_lvl;
      r_fall <= ~w_filt & r_lvl;
    end
  end

  assign o_level = r_lvl;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with 7-bit address and 256-byte register port: pointer write, data write, auto-increment read.
// Event latency 3 clk (5 with I2C_SLAVE_GLITCH_FILTER_EN); sda_oe moves 1 clk after a detected scl fall.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'b1110000
)
(
  input  logic            clk,
  input  logic            reset,
  i2c_slave_regs_if.slave bus
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;

  i2c_state_e           r_state;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           r_shift;
  logic [7:0]           r_addr;
  logic [7:0]           r_wdata;
  logic                 r_we;
  logic                 r_oe;
  logic                 r_busy;
  logic                 r_rw;
  logic                 r_mack;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .reset   (reset),
    .i_line  (bus.scl_in),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .reset   (reset),
    .i_line  (bus.sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;
  assign w_byte  = {r_shift[6:0], w_sda_lvl};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= 8'h00;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_mack    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Bus conditions take priority over any coincident scl edge.
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_oe      <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_oe      <= 1'b0;
        r_bit_cnt <= '0;
        r_shift   <= 8'h00;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_IGNORE: begin
          end

          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                if (w_byte[7:1] == DEV_ADDR) begin
                  r_state <= ST_ADDR_ACK;
                  r_rw    <= w_byte[0];
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end

          // ACK states: first scl fall pulls sda, second fall releases it and ends the byte.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd0) begin
                r_oe      <= 1'b1;
                r_bit_cnt <= 4'd1;
              end else begin
                r_oe      <= 1'b0;
                r_bit_cnt <= '0;
                if (r_state == ST_ADDR_ACK && r_rw == I2C_RW_READ) begin
                  r_state <= ST_RDATA;
                  r_oe    <= ~bus.reg_rdata[7];
                  r_shift <= {bus.reg_rdata[6:0], 1'b0};
                end else if (r_state == ST_ADDR_ACK) begin
                  r_state <= ST_PTR;
                end else begin
                  r_state <= ST_WDATA;
                  if (r_state == ST_WDATA_ACK) begin
                    r_addr <= r_addr + 8'd1;
                  end
                end
              end
            end
          end

          ST_PTR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                r_addr    <= w_byte;
                r_state   <= ST_PTR_ACK;
              end
            end
          end

          ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                r_wdata   <= w_byte;
                r_we      <= 1'b1;
                r_state   <= ST_WDATA_ACK;
              end
            end
          end

          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_oe      <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= ST_RDATA_ACK;
              end else begin
                r_oe    <= ~r_shift[7];
                r_shift <= {r_shift[6:0], 1'b0};
              end
            end
          end

          // Pointer advances on the ACK sample so reg_rdata is settled by the next fall.
          ST_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_mack <= (w_sda_lvl == I2C_ACK);
              if (w_sda_lvl == I2C_ACK) begin
                r_addr <= r_addr + 8'd1;
              end
            end else if (w_scl_fall) begin
              if (r_mack) begin
                r_state <= ST_RDATA;
                r_oe    <= ~bus.reg_rdata[7];
                r_shift <= {bus.reg_rdata[6:0], 1'b0};
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe    = r_oe;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_we    = r_we;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, behavioural register file, write/read scoreboards.
module tb_i2c_slave_regs;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int oe_hi   = 0;

  logic [7:0]  mem [256];
  logic [15:0] q_we [$];
  logic [7:0]  q_rd [$];

  always #5 clk = ~clk;

  i2c_slave_regs_if bus ();

  assign bus.scl_in    = m_scl;
  assign bus.sda_in    = m_sda & ~bus.sda_oe;
  assign bus.reg_rdata = mem[bus.reg_addr];

  i2c_slave_regs #(.DEV_ADDR(7'b1110000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Write scoreboard and register-file update.
  always @(negedge clk) begin
    if (bus.sda_oe) oe_hi++;
    if (bus.reg_we) begin
      if (q_we.size() == 0) begin
        chk_eq("we_unexpected", {bus.reg_addr, bus.reg_wdata}, 16'hxxxx);
      end else begin
        chk_eq("we_addr_data", {bus.reg_addr, bus.reg_wdata}, q_we.pop_front());
      end
      mem[bus.reg_addr] = bus.reg_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_wr(input logic b);
    clks(4); m_sda = b;
    clks(4); m_scl = 1'b1;
    clks(8); m_scl = 1'b0;
  endtask

  task automatic bit_rd(output logic b);
    clks(4); m_sda = 1'b1;
    clks(4); m_scl = 1'b1;
    clks(4); b = bus.sda_in;
    clks(4); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    clks(4); m_sda = 1'b1;
    clks(4); m_scl = 1'b1;
    clks(8); m_sda = 1'b0;
    clks(8); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(4); m_sda = 1'b0;
    clks(4); m_scl = 1'b1;
    clks(8); m_sda = 1'b1;
    clks(8);
  endtask

  task automatic send(input logic [7:0] d, input string tag, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) bit_wr(d[i]);
    bit_rd(a);
    chk_eq(tag, a, exp_ack);
  endtask

  task automatic recv(input string tag, input logic ack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) bit_rd(d[i]);
    bit_wr(ack);
    if (q_rd.size() == 0) chk_eq({tag, "_noexp"}, d, 8'hxx);
    else chk_eq(tag, d, q_rd.pop_front());
  endtask

  initial begin
    int oe_mark;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i[7:0]);

    clks(3);
    chk_eq("rst_sda_oe", bus.sda_oe, 1'b0);
    chk_eq("rst_reg_we", bus.reg_we, 1'b0);
    chk_eq("rst_busy", bus.busy, 1'b0);
    chk_eq("rst_reg_addr", bus.reg_addr, 8'h00);
    chk_eq("rst_reg_wdata", bus.reg_wdata, 8'h00);
    reset = 1'b0;
    clks(10);

    // Plain write: pointer 0x10, data 0xB2.
    i2c_start();
    send(8'hE0, "wr_addr_ack", 1'b0);
    chk_eq("wr_busy", bus.busy, 1'b1);
    send(8'h10, "wr_ptr_ack", 1'b0);
    q_we.push_back({8'h10, 8'hB2});
    send(8'hB2, "wr_data_ack", 1'b0);
    i2c_stop();
    chk_eq("wr_final_ptr", bus.reg_addr, 8'h11);
    chk_eq("wr_busy_after_stop", bus.busy, 1'b0);

    // Foreign address: never acknowledged, no writes.
    oe_mark = oe_hi;
    i2c_start();
    send(8'hA0, "mis_addr_nack", 1'b1);
    chk_eq("mis_busy", bus.busy, 1'b0);
    send(8'h55, "mis_byte_nack", 1'b1);
    i2c_stop();
    chk_eq("mis_oe_count", oe_hi - oe_mark, 0);
    chk_eq("mis_ptr_kept", bus.reg_addr, 8'h11);

    // Read across the pointer wrap.
    i2c_start();
    send(8'hE0, "rd_waddr_ack", 1'b0);
    send(8'hFE, "rd_ptr_ack", 1'b0);
    i2c_start();
    send(8'hE1, "rd_raddr_ack", 1'b0);
    q_rd.push_back(init_val(8'hFE));
    recv("rd_byte0", 1'b0);
    q_rd.push_back(init_val(8'hFF));
    recv("rd_byte1", 1'b0);
    q_rd.push_back(init_val(8'h00));
    recv("rd_byte2", 1'b1);
    i2c_stop();
    chk_eq("rd_ptr_wrap", bus.reg_addr, 8'h00);

    // Short write: pointer only.
    i2c_start();
    send(8'hE0, "sw_addr_ack", 1'b0);
    send(8'h42, "sw_ptr_ack", 1'b0);
    i2c_stop();
    chk_eq("sw_ptr", bus.reg_addr, 8'h42);

    // Abort mid-byte with repeated START, then a full write proves the slave is back in ADDR.
    i2c_start();
    send(8'hE0, "ab_addr_ack", 1'b0);
    send(8'h20, "ab_ptr_ack", 1'b0);
    bit_wr(1'b1); bit_wr(1'b0); bit_wr(1'b1);
    i2c_start();
    chk_eq("ab_ptr_kept", bus.reg_addr, 8'h20);
    send(8'hE0, "ab_readdr_ack", 1'b0);
    send(8'h30, "ab_ptr2_ack", 1'b0);
    q_we.push_back({8'h30, 8'h77});
    send(8'h77, "ab_data_ack", 1'b0);
    i2c_stop();
    chk_eq("ab_final_ptr", bus.reg_addr, 8'h31);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clk sda pulse during scl high must not look like START/STOP.
    i2c_start();
    send(8'hE0, "gl_addr_ack", 1'b0);
    bit_wr(1'b0);
    clks(4); m_sda = 1'b1;
    clks(4); m_scl = 1'b1;
    clks(3); m_sda = 1'b0;
    clks(1); m_sda = 1'b1;
    clks(4); m_scl = 1'b0;
    for (int i = 0; i < 6; i++) bit_wr(1'b0);
    begin
      logic a;
      bit_rd(a);
      chk_eq("gl_ptr_ack", a, 1'b0);
    end
    chk_eq("gl_busy", bus.busy, 1'b1);
    q_we.push_back({8'h40, 8'h5C});
    send(8'h5C, "gl_data_ack", 1'b0);
    i2c_stop();
`endif

    // Reset while the slave holds the ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_wr(i == 7 || i == 6 || i == 5);
    for (int i = 0; i < 20 && !bus.sda_oe; i++) @(negedge clk);
    chk_eq("rm_oe_before", bus.sda_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_eq("rm_sda_oe", bus.sda_oe, 1'b0);
    chk_eq("rm_busy", bus.busy, 1'b0);
    chk_eq("rm_reg_addr", bus.reg_addr, 8'h00);
    chk_eq("rm_reg_wdata", bus.reg_wdata, 8'h00);
    chk_eq("rm_reg_we", bus.reg_we, 1'b0);
    clks(2);
    reset = 1'b0;
    m_sda = 1'b1;
    clks(4); m_scl = 1'b1;
    clks(10);
    chk_eq("rm_idle_oe", bus.sda_oe, 1'b0);

    chk_eq("we_left", q_we.size(), 0);
    chk_eq("rd_left", q_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
